// File: rtl/ahb_wait_mem_slave_if.sv
// rtl/ahb_wait_mem_slave_if.sv - AHB-lite bus signal bundle for the wait-state memory slave
interface ahb_wait_mem_slave_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  HSEL;
   logic [31:0]           HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [2:0]            HSIZE;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic                  HREADYIN;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic                  HREADYOUT;
   logic [1:0]            HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
      input  HRDATA, HREADYOUT, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
      output HRDATA, HREADYOUT, HRESP
   );
endinterface

// File: rtl/ahb_wait_mem_slave.sv
// rtl/ahb_wait_mem_slave.sv - AHB-lite memory slave with programmable wait states and error response
module ahb_wait_mem_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_BYTES  = 1024,
   parameter int MAX_WAIT   = 15
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   ahb_wait_mem_slave_if.slave   bus,
   input  logic [3:0]            wait_cfg,
   input  logic                  err_inject
);

   localparam int         NB    = DATA_WIDTH / 8;
   localparam int         LB    = $clog2(NB);
   localparam int         AW    = $clog2(MEM_BYTES);
   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t          state_q, state_d;
   logic            fin_q, fin_d;       // current cycle is the final OKAY data phase
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            write_q, write_d;
   logic [2:0]      size_q, size_d;

   logic [7:0]      mem [MEM_BYTES];

   logic            ready_int;
   logic            accept;
   logic            req_err;
   logic [3:0]      wait_clamp;
   logic [NB-1:0]   lane_sel;
   logic [AW-1:0]   base;
   logic            wr_en;
   logic            rd_en;
   logic [DATA_WIDTH-1:0] rdata;

   // Address-phase acceptance and request validity checks on the live bus inputs
   always_comb begin
      wait_clamp = (wait_cfg > MAX_W) ? MAX_W : wait_cfg;
      ready_int  = (state_q != ST_WAIT) && (state_q != ST_ERR1);
      accept     = bus.HSEL && bus.HTRANS[1] && bus.HREADYIN && ready_int;
      req_err    = (bus.HSIZE > 3'(LB))
                || ((bus.HADDR & ((32'd1 << bus.HSIZE) - 32'd1)) != 32'd0)
                || (bus.HADDR >= 32'(MEM_BYTES))
                || err_inject;
   end

   // Next-state logic: data-phase sequencing and address-phase capture
   always_comb begin
      state_d = state_q;
      fin_d   = 1'b0;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      case (state_q)
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_IDLE;
               fin_d   = 1'b1;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
      // Only IDLE and ERR2 can accept, so this overrides their default exit
      if (accept) begin
         addr_d  = bus.HADDR[AW-1:0];
         write_d = bus.HWRITE;
         size_d  = bus.HSIZE;
         if (req_err) begin
            state_d = ST_ERR1;
            cnt_d   = 4'd0;
         end else if (wait_clamp == 4'd0) begin
            state_d = ST_IDLE;
            fin_d   = 1'b1;
            cnt_d   = 4'd0;
         end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_clamp;
         end
      end
   end

   // State and latched-control registers
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         fin_q   <= 1'b0;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         fin_q   <= fin_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         size_q  <= size_d;
      end
   end

   // Byte-lane selection and read data for the final OKAY data-phase cycle
   always_comb begin
      base  = addr_q & ~AW'(NB - 1);
      wr_en = !HRESET && (state_q == ST_IDLE) && fin_q && write_q;
      rd_en = !HRESET && (state_q == ST_IDLE) && fin_q && !write_q;
      rdata = '0;
      for (int i = 0; i < NB; i++) begin
         lane_sel[i] = (i >= int'(addr_q[LB-1:0]))
                    && (i < int'(addr_q[LB-1:0]) + (1 << size_q));
         if (rd_en && lane_sel[i]) begin
            rdata[8*i +: 8] = mem[base + AW'(i)];
         end
      end
   end

   // Memory write commits at the edge ending the final OKAY data phase
   always_ff @(posedge HCLK) begin
      if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (lane_sel[i]) begin
               mem[base + AW'(i)] <= bus.HWDATA[8*i +: 8];
            end
         end
      end
   end

   // Bus responses, forced to idle values while reset is held
   always_comb begin
      bus.HREADYOUT = HRESET ? 1'b1 : ready_int;
      bus.HRESP     = (!HRESET && ((state_q == ST_ERR1) || (state_q == ST_ERR2))) ? 2'b01 : 2'b00;
      bus.HRDATA    = rdata;
   end

endmodule

// File: tb/tb_ahb_wait_mem_slave.sv
// tb/tb_ahb_wait_mem_slave.sv - randomized and directed bench for ahb_wait_mem_slave
module tb_ahb_wait_mem_slave;

   localparam int DW = 32;
   localparam int MB = 1024;
   localparam int MW = 10;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic [3:0] wait_cfg;
   logic       err_inject;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] model [MB];

   ahb_wait_mem_slave_if #(.DATA_WIDTH(DW)) bus ();
   assign bus.HREADYIN = bus.HREADYOUT;

   ahb_wait_mem_slave #(
      .DATA_WIDTH (DW),
      .MEM_BYTES  (MB),
      .MAX_WAIT   (MW)
   ) dut (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .bus        (bus.slave),
      .wait_cfg   (wait_cfg),
      .err_inject (err_inject)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time exhausted");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input logic [31:0] addr, input logic [2:0] size, input logic inj);
      longint a = longint'(addr);
      longint n = longint'(1) << size;
      return (a >= MB) || (size > 3'd2) || ((a % n) != 0) || inj;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [2:0] size);
      logic [31:0] r = '0;
      int a   = int'(addr);
      int off = a % 4;
      int n   = 1 << size;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + n) r[8*i +: 8] = model[a - off + i];
      end
      return r;
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
      int a   = int'(addr);
      int off = a % 4;
      int n   = 1 << size;
      for (int i = 0; i < 4; i++) begin
         if (i >= off && i < off + n) model[a - off + i] = d[8*i +: 8];
      end
   endtask

   // One complete transfer: starts and ends just after a rising edge
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] cfg, input logic inj,
                       output int lows, output logic [31:0] rd, output logic [1:0] rs);
      bit          err   = model_err(addr, size, inj);
      int          nwait = (int'(cfg) > MW) ? MW : int'(cfg);
      logic [31:0] exp_rd;
      bit          done  = 0;
      exp_rd = (!wr && !err) ? model_read(addr, size) : 32'd0;
      lows = 0; rd = '0; rs = '0;
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = addr; bus.HWRITE = wr;
      bus.HSIZE = size; wait_cfg = cfg; err_inject = inj;
      @(posedge HCLK); #1;
      bus.HTRANS = 2'b00; bus.HSEL = 1'($urandom); bus.HADDR = $urandom;
      bus.HWDATA = wdata; wait_cfg = 4'($urandom); err_inject = 1'($urandom);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge HCLK);
         if (bus.HREADYOUT) begin
            done = 1;
            rd = bus.HRDATA; rs = bus.HRESP;
            check("final_resp", 64'(bus.HRESP), err ? 64'd1 : 64'd0);
            check("final_rdata", 64'(bus.HRDATA), 64'(exp_rd));
         end else begin
            lows++;
            check("wait_resp", 64'(bus.HRESP), err ? 64'd1 : 64'd0);
            check("wait_rdata", 64'(bus.HRDATA), 64'd0);
         end
         @(posedge HCLK); #1;
      end
      check("xfer_done", 64'(done), 64'd1);
      check("low_cycles", 64'(lows), err ? 64'd1 : 64'(nwait));
      if (wr && !err) model_write(addr, size, wdata);
   endtask

   task automatic idle_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         case ($urandom_range(0, 2))
            0: begin bus.HSEL = 1'b0; bus.HTRANS = 2'b10; end
            1: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b00; end
            default: begin bus.HSEL = 1'b1; bus.HTRANS = 2'b01; end
         endcase
         bus.HADDR = $urandom & 32'h3FC; bus.HWRITE = 1'($urandom);
         @(negedge HCLK);
         check("idle_ready", 64'(bus.HREADYOUT), 64'd1);
         check("idle_resp", 64'(bus.HRESP), 64'd0);
         check("idle_rdata", 64'(bus.HRDATA), 64'd0);
         @(posedge HCLK); #1;
      end
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
   endtask

   initial begin
      int          l;
      logic [31:0] r;
      logic [1:0]  rs;
      logic        p_wr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [31:0] p_ad [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h0, 32'h4};
      logic [31:0] p_dt [6];
      logic [31:0] exp_rd;

      HRESET = 1'b1; wait_cfg = 4'd0; err_inject = 1'b0;
      bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
      bus.HSIZE = 3'd0; bus.HWDATA = '0;
      @(posedge HCLK);
      @(negedge HCLK);
      check("rst_ready", 64'(bus.HREADYOUT), 64'd1);
      check("rst_resp", 64'(bus.HRESP), 64'd0);
      check("rst_rdata", 64'(bus.HRDATA), 64'd0);
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      idle_cycles(6);

      // Zero-wait write then read
      xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'd0, 1'b0, l, r, rs);
      check("zw_wr_lows", 64'(l), 64'd0);
      xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'd0, 1'b0, l, r, rs);
      check("zw_rd_data", 64'(r), 64'hDEADBEEF);
      check("zw_rd_resp", 64'(rs), 64'd0);

      // Three wait states
      xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'd3, 1'b0, l, r, rs);
      check("w3_lows", 64'(l), 64'd3);
      check("w3_data", 64'(r), 64'hDEADBEEF);

      // Byte lane merge
      xfer(1'b1, 32'h13, 3'd0, 32'hA5A5A5A5, 4'd0, 1'b0, l, r, rs);
      xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'd0, 1'b0, l, r, rs);
      check("byte_merge", 64'(r), 64'hA5ADBEEF);

      // Error responses leave memory alone
      xfer(1'b0, 32'h400, 3'd2, 32'h0, 4'd2, 1'b0, l, r, rs);
      check("oob_lows", 64'(l), 64'd1);
      check("oob_resp", 64'(rs), 64'd1);
      xfer(1'b1, 32'h11, 3'd1, 32'h55555555, 4'd0, 1'b0, l, r, rs);
      check("misalign_resp", 64'(rs), 64'd1);
      xfer(1'b1, 32'h10, 3'd2, 32'h0BADF00D, 4'd0, 1'b1, l, r, rs);
      check("inject_resp", 64'(rs), 64'd1);
      xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'd0, 1'b0, l, r, rs);
      check("err_unchanged", 64'(r), 64'hA5ADBEEF);

      // Wait setting above the limit is clamped
      xfer(1'b0, 32'h10, 3'd2, 32'h0, 4'd15, 1'b0, l, r, rs);
      check("clamp_lows", 64'(l), 64'(MW));

      // Back-to-back zero-wait pipeline
      for (int k = 0; k < 6; k++) p_dt[k] = $urandom;
      for (int k = 0; k <= 6; k++) begin
         if (k < 6) begin
            bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = p_ad[k];
            bus.HWRITE = p_wr[k]; bus.HSIZE = 3'd2; wait_cfg = 4'd0; err_inject = 1'b0;
         end else begin
            bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
         end
         if (k > 0) bus.HWDATA = p_dt[k-1];
         exp_rd = (k > 0 && !p_wr[k-1]) ? model_read(p_ad[k-1], 3'd2) : 32'd0;
         @(negedge HCLK);
         check("pipe_ready", 64'(bus.HREADYOUT), 64'd1);
         check("pipe_resp", 64'(bus.HRESP), 64'd0);
         check("pipe_rdata", 64'(bus.HRDATA), 64'(exp_rd));
         if (k > 0 && p_wr[k-1]) model_write(p_ad[k-1], 3'd2, p_dt[k-1]);
         @(posedge HCLK); #1;
      end

      // Reset in the second wait cycle abandons the write
      bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0; bus.HWRITE = 1'b1;
      bus.HSIZE = 3'd2; wait_cfg = 4'd5; err_inject = 1'b0;
      @(posedge HCLK); #1;
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = 32'h12345678;
      @(negedge HCLK);
      check("rw_wait1", 64'(bus.HREADYOUT), 64'd0);
      @(posedge HCLK); #1;
      HRESET = 1'b1;
      @(negedge HCLK);
      check("rw_forced_ready", 64'(bus.HREADYOUT), 64'd1);
      @(posedge HCLK); #1;
      HRESET = 1'b0;
      @(negedge HCLK);
      check("rw_after_ready", 64'(bus.HREADYOUT), 64'd1);
      check("rw_after_resp", 64'(bus.HRESP), 64'd0);
      @(posedge HCLK); #1;
      xfer(1'b0, 32'h0, 3'd2, 32'h0, 4'd1, 1'b0, l, r, rs);
      check("rw_prior_value", 64'(r), 64'(p_dt[0]));

      // Fill memory so every later read has a known model value
      for (int w = 0; w < MB / 4; w++) begin
         xfer(1'b1, 32'(w * 4), 3'd2, $urandom, 4'd0, 1'b0, l, r, rs);
      end

      // Randomized transfers against the model
      for (int t = 0; t < 300; t++) begin
         logic [31:0] a;
         logic [2:0]  s = 3'($urandom_range(0, 3));
         int          pick = $urandom_range(0, 9);
         if (pick < 8)       a = $urandom_range(0, MB - 1);
         else if (pick == 8) a = $urandom_range(MB, MB + 80);
         else                a = $urandom;
         if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << s) - 32'd1);
         xfer(1'($urandom), a, s, $urandom, 4'($urandom), ($urandom_range(0, 7) == 0), l, r, rs);
         if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
